// File: rtl/codificador_imediato.sv
// codificador_imediato: packs decoded RISC-V fields (I / S / SB formats) into a
// 32-bit instruction word and hands it to instruction memory together with a
// post-incremented write address.
// Optional feature macro: CODIFICADOR_VERIFICA_FAIXA_EN
//   defined   -> immediates are range-checked. Rejected requests pulse
//                erro_imediato and bump a saturating error counter.
//   undefined -> immediates are truncated into the format's bit positions,
//                format 11 emits 32'h0, and the error outputs are tied to 0.
module codificador_imediato #(
    parameter int                          LARGURA_ENDERECO = 32,
    parameter logic [LARGURA_ENDERECO-1:0] ENDERECO_INICIAL = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        entrada_valida,
    output logic                        entrada_pronta,
    input  logic [1:0]                  fonte_imediato,
    input  logic [6:0]                  opcode,
    input  logic [2:0]                  funct3,
    input  logic [4:0]                  rd,
    input  logic [4:0]                  rs1,
    input  logic [4:0]                  rs2,
    input  logic [31:0]                 imediato,
    output logic                        saida_valida,
    input  logic                        saida_pronta,
    output logic [31:0]                 instrucao,
    output logic [LARGURA_ENDERECO-1:0] endereco_escrita,
    output logic                        erro_imediato,
    output logic [7:0]                  contador_erros
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CODIFICA = 2'd1,
        SAIDA    = 2'd2
    } estado_t;

    // Field snapshot taken in the accept cycle; the inputs are free to change afterwards.
    typedef struct packed {
        logic [1:0]  formato;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imediato;
    } requisicao_t;

    estado_t     estado, proximo;
    requisicao_t req;
    logic [31:0] palavra;
    logic        faixa_ok;
    logic        aceita;
    logic        handshake;

    assign entrada_pronta = (estado == OCIOSO);
    assign saida_valida   = (estado == SAIDA);
    assign aceita         = entrada_pronta & entrada_valida;
    assign handshake      = saida_valida & saida_pronta;

    // Scatter the captured immediate into the format-specific bit positions.
    always_comb begin
        palavra = '0;
        case (req.formato)
            2'b00: palavra = {req.imediato[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            2'b01: palavra = {req.imediato[11:5], req.rs2, req.rs1, req.funct3,
                              req.imediato[4:0], req.opcode};
            2'b10: palavra = {req.imediato[12], req.imediato[10:5], req.rs2, req.rs1,
                              req.funct3, req.imediato[4:1], req.imediato[11], req.opcode};
            default: palavra = '0;
        endcase
    end

`ifdef CODIFICADOR_VERIFICA_FAIXA_EN
    // An immediate fits in N signed bits iff bits [31:N-1] are all copies of the sign.
    // For SB the evenness test also excludes 4095, so the upper limit is 4094.
    always_comb begin
        faixa_ok = 1'b0;
        case (req.formato)
            2'b00, 2'b01: faixa_ok = (&req.imediato[31:11]) | ~(|req.imediato[31:11]);
            2'b10:        faixa_ok = ((&req.imediato[31:12]) | ~(|req.imediato[31:12]))
                                     & ~req.imediato[0];
            default:      faixa_ok = 1'b0;
        endcase
    end
`else
    // Upper immediate bits are deliberately discarded in the truncating build.
    logic imediato_alto_unused;
    assign imediato_alto_unused = ^req.imediato[31:13];
    assign faixa_ok             = 1'b1;
`endif

    // Next-state logic: CODIFICA always lasts exactly one cycle.
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:   if (entrada_valida) proximo = CODIFICA;
            CODIFICA: proximo = faixa_ok ? SAIDA : OCIOSO;
            SAIDA:    if (saida_pronta) proximo = OCIOSO;
            default:  proximo = OCIOSO;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    // Capture the request fields on the accept edge only.
    always_ff @(posedge clk) begin
        if (aceita)
            req <= {fonte_imediato, opcode, funct3, rd, rs1, rs2, imediato};
    end

    // Output word is loaded once when the encode passes and held through SAIDA.
    always_ff @(posedge clk) begin
        if (reset)                              instrucao <= '0;
        else if (estado == CODIFICA && faixa_ok) instrucao <= palavra;
    end

    // Write address advances (modulo 2^LARGURA_ENDERECO) only on a completed handshake.
    always_ff @(posedge clk) begin
        if (reset)          endereco_escrita <= ENDERECO_INICIAL;
        else if (handshake) endereco_escrita <= endereco_escrita + LARGURA_ENDERECO'(4);
    end

`ifdef CODIFICADOR_VERIFICA_FAIXA_EN
    logic rejeita;
    assign rejeita = (estado == CODIFICA) & ~faixa_ok;

    // One-cycle error pulse plus a counter that sticks at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            erro_imediato  <= 1'b0;
            contador_erros <= '0;
        end else begin
            erro_imediato <= rejeita;
            if (rejeita && contador_erros != 8'hFF)
                contador_erros <= contador_erros + 8'd1;
        end
    end
`else
    assign erro_imediato  = 1'b0;
    assign contador_erros = '0;
`endif

endmodule

// File: tb/tb_codificador_imediato.sv
// Bench for codificador_imediato: directed test-plan cases with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level reference model. Follows the CODIFICADOR_VERIFICA_FAIXA_EN
// build option of the design.
module tb_codificador_imediato;

    logic        clk = 1'b0;
    logic        reset;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic [1:0]  fonte_imediato;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imediato;
    logic        saida_valida;
    logic        saida_pronta;
    logic [31:0] instrucao;
    logic [31:0] endereco_escrita;
    logic        erro_imediato;
    logic [7:0]  contador_erros;

    codificador_imediato #(
        .LARGURA_ENDERECO(32),
        .ENDERECO_INICIAL(32'h0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .entrada_valida  (entrada_valida),
        .entrada_pronta  (entrada_pronta),
        .fonte_imediato  (fonte_imediato),
        .opcode          (opcode),
        .funct3          (funct3),
        .rd              (rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .imediato        (imediato),
        .saida_valida    (saida_valida),
        .saida_pronta    (saida_pronta),
        .instrucao       (instrucao),
        .endereco_escrita(endereco_escrita),
        .erro_imediato   (erro_imediato),
        .contador_erros  (contador_erros)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
        end
    endtask

    // Reference encoding from the format rules using plain shift/mask arithmetic.
    function automatic void ref_encode(input logic [1:0] f, input logic [6:0] op,
                                       input logic [2:0] f3, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [31:0] imm,
                                       output bit ok, output logic [31:0] w);
        int v;
        int unsigned u, base;
        v = imm;
        u = imm;
        base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
        case (f)
            2'b00: w = ((u & 32'hFFF) << 20) | base | (32'(d) << 7);
            2'b01: w = (((u >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base
                       | ((u & 32'h1F) << 7);
            2'b10: w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                       | (32'(s2) << 20) | base | (((u >> 1) & 32'hF) << 8)
                       | (((u >> 11) & 32'h1) << 7);
            default: w = 32'h0;
        endcase
`ifdef CODIFICADOR_VERIFICA_FAIXA_EN
        case (f)
            2'b00, 2'b01: ok = (v >= -2048) && (v <= 2047);
            2'b10:        ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            default:      ok = 1'b0;
        endcase
`else
        ok = 1'b1;
`endif
    endfunction

    // Transaction-level model: a request is accepted when the block is idle, is
    // resolved one cycle later, and an emitted word waits for the consumer.
    bit          m_stage, m_ok, m_out_valid, m_err;
    logic [31:0] m_word, m_out_instr, m_addr;
    int          m_cnt;

    always @(posedge clk) begin
        m_err = 1'b0;
        if (reset) begin
            m_stage     = 1'b0;
            m_out_valid = 1'b0;
            m_out_instr = 32'h0;
            m_addr      = 32'h0;
            m_cnt       = 0;
        end else if (m_out_valid) begin
            if (saida_pronta) begin
                m_out_valid = 1'b0;
                m_addr      = m_addr + 32'd4;
            end
        end else if (m_stage) begin
            m_stage = 1'b0;
            if (m_ok) begin
                m_out_valid = 1'b1;
                m_out_instr = m_word;
            end else begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end else if (entrada_valida) begin
            ref_encode(fonte_imediato, opcode, funct3, rd, rs1, rs2, imediato, m_ok, m_word);
            m_stage = 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("entrada_pronta", {31'b0, entrada_pronta}, {31'b0, !m_stage && !m_out_valid});
            check("saida_valida", {31'b0, saida_valida}, {31'b0, m_out_valid});
            check("endereco_escrita", endereco_escrita, m_addr);
            check("erro_imediato", {31'b0, erro_imediato}, {31'b0, m_err});
            check("contador_erros", {24'b0, contador_erros}, 32'(m_cnt));
            if (m_out_valid) check("instrucao", instrucao, m_out_instr);
        end
    end

    function automatic logic [31:0] pick_imm();
        int b[12];
        b = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097, -4098, 5, -8};
        case ($urandom_range(0, 3))
            0:       return 32'(b[$urandom_range(0, 11)]);
            1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            default: return $urandom;
        endcase
    endfunction

    // Present one request at a negedge and hold it across the accept edge.
    task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] imm);
        int t = 0;
        while (!entrada_pronta && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("send_ready_timeout", {31'b0, entrada_pronta}, 32'd1);
        fonte_imediato = f; opcode = op; funct3 = f3;
        rd = d; rs1 = s1; rs2 = s2; imediato = imm;
        entrada_valida = 1'b1;
        @(negedge clk);
        entrada_valida = 1'b0;
        // Scramble the fields: they must not be resampled after acceptance.
        opcode = 7'($urandom); funct3 = 3'($urandom); rd = 5'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); imediato = $urandom;
    endtask

    task automatic wait_out();
        int t = 0;
        while (!saida_valida && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("wait_saida_valida", {31'b0, saida_valida}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        bit          pk;
        logic [31:0] pw, hold;
        logic [31:0] addr_beq;

        // Pin the reference model itself to hand-computed words.
        ref_encode(2'b00, 7'b0010011, 3'b111, 5'd1, 5'd0, 5'd0, 32'd7, pk, pw);
        check("model_andi", pw, 32'h00707093);
        ref_encode(2'b01, 7'b0100011, 3'b001, 5'd0, 5'd0, 5'd1, 32'd4, pk, pw);
        check("model_sh", pw, 32'h00101223);
        ref_encode(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd6, 5'd1, -32'sd8, pk, pw);
        check("model_beq", pw, 32'hFE130CE3);

        reset = 1'b1; entrada_valida = 1'b0; saida_pronta = 1'b1;
        fonte_imediato = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0;
        imediato = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_entrada_pronta", {31'b0, entrada_pronta}, 32'd1);
        check("rst_saida_valida", {31'b0, saida_valida}, 32'd0);
        check("rst_instrucao", instrucao, 32'h0);
        check("rst_erro", {31'b0, erro_imediato}, 32'd0);
        check("rst_contador", {24'b0, contador_erros}, 32'd0);
        check("rst_endereco", endereco_escrita, 32'h0);
        reset = 1'b0;

        // andi x1,x0,7 : two-cycle latency, address 0.
        send(2'b00, 7'b0010011, 3'b111, 5'd1, 5'd0, 5'd9, 32'd7);
        check("lat_codifica", {31'b0, saida_valida}, 32'd0);
        @(negedge clk);
        check("lat_saida", {31'b0, saida_valida}, 32'd1);
        check("andi_word", instrucao, 32'h00707093);
        check("andi_addr", endereco_escrita, 32'h0);
        @(negedge clk);
        check("andi_ready_after", {31'b0, entrada_pronta}, 32'd1);
        check("andi_addr_inc", endereco_escrita, 32'h4);

        // sh x1,4(x0) : rd is garbage and must be ignored.
        send(2'b01, 7'b0100011, 3'b001, 5'd17, 5'd0, 5'd1, 32'd4);
        wait_out();
        check("sh_word", instrucao, 32'h00101223);
        check("sh_addr", endereco_escrita, 32'h4);
        @(negedge clk);

`ifdef CODIFICADOR_VERIFICA_FAIXA_EN
        // Two rejects: I with 2048, SB with odd offset.
        send(2'b00, 7'b0010011, 3'b000, 5'd0, 5'd0, 5'd0, 32'd2048);
        check("rej1_no_pulse_yet", {31'b0, erro_imediato}, 32'd0);
        @(negedge clk);
        check("rej1_pulse", {31'b0, erro_imediato}, 32'd1);
        check("rej1_ready", {31'b0, entrada_pronta}, 32'd1);
        check("rej1_count", {24'b0, contador_erros}, 32'd1);
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0, 32'd5);
        check("rej1_pulse_end", {31'b0, erro_imediato}, 32'd0);
        @(negedge clk);
        check("rej2_pulse", {31'b0, erro_imediato}, 32'd1);
        check("rej2_count", {24'b0, contador_erros}, 32'd2);
        check("rej2_no_valid", {31'b0, saida_valida}, 32'd0);
        @(negedge clk);
        check("rej2_pulse_end", {31'b0, erro_imediato}, 32'd0);
        addr_beq = 32'h8;
`else
        // Truncating build: the same requests are emitted with clipped immediates.
        send(2'b00, 7'b0010011, 3'b000, 5'd0, 5'd0, 5'd0, 32'd2048);
        wait_out();
        check("trunc_i_word", instrucao, 32'h80000013);
        @(negedge clk);
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0, 32'd5);
        wait_out();
        check("trunc_sb_word", instrucao, 32'h00000263);
        check("trunc_no_error", {24'b0, contador_erros}, 32'd0);
        @(negedge clk);
        addr_beq = 32'h10;
`endif

        // beq x6,x1,-8 held in SAIDA, then reset mid-operation.
        saida_pronta = 1'b0;
        send(2'b10, 7'b1100011, 3'b000, 5'd0, 5'd6, 5'd1, -32'sd8);
        wait_out();
        check("beq_word", instrucao, 32'hFE130CE3);
        check("beq_addr", endereco_escrita, addr_beq);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_saida_valida", {31'b0, saida_valida}, 32'd0);
        check("midrst_endereco", endereco_escrita, 32'h0);
        check("midrst_contador", {24'b0, contador_erros}, 32'd0);
        check("midrst_ready", {31'b0, entrada_pronta}, 32'd1);
        reset = 1'b0;

        // Back-pressure for 10 cycles, then release.
        send(2'b00, 7'b0010011, 3'b111, 5'd1, 5'd0, 5'd0, 32'd7);
        wait_out();
        hold = instrucao;
        check("bp_word", hold, 32'h00707093);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, saida_valida}, 32'd1);
            check("bp_stable", instrucao, hold);
            check("bp_not_ready", {31'b0, entrada_pronta}, 32'd0);
            check("bp_addr", endereco_escrita, 32'h0);
        end
        saida_pronta = 1'b1;
        @(negedge clk);
        check("bp_release_addr", endereco_escrita, 32'h4);
        check("bp_release_valid", {31'b0, saida_valida}, 32'd0);

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 6000; c++) begin
            entrada_valida = ($urandom_range(0, 3) != 0);
            fonte_imediato = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            opcode   = 7'($urandom);
            funct3   = 3'($urandom);
            rd       = 5'($urandom);
            rs1      = 5'($urandom);
            rs2      = 5'($urandom);
            imediato = pick_imm();
            saida_pronta = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        entrada_valida = 1'b0;
        saida_pronta   = 1'b1;
        repeat (5) @(negedge clk);
`ifdef CODIFICADOR_VERIFICA_FAIXA_EN
        check("count_saturated", {24'b0, contador_erros}, 32'd255);
`else
        check("count_tied_zero", {24'b0, contador_erros}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
